// File: rtl/z2_cycle_ctrl.sv
// Zorro II / 68000 slave-cycle controller: strobe synchronisers, fixed-priority target
// arbitration, per-channel wait states and DTACK/OVR generation. Optional Z2_TIMEOUT_EN.
module z2_cycle_ctrl #(
  parameter int                NUM_CH         = 5,
  parameter int                SYNC_STAGES    = 2,
  parameter int                WS_W           = 3,
  parameter logic [NUM_CH-1:0] BUS_MASK       = 5'b00111,
  parameter int                TIMEOUT_CYCLES = 255
) (
  input  logic                   MEMCLK,
  input  logic                   RESET,
  input  logic                   AS_n,
  input  logic                   UDS_n,
  input  logic                   LDS_n,
  input  logic                   RW,
  input  logic [NUM_CH-1:0]      ch_access,
  input  logic [NUM_CH-1:0]      ch_ready,
  input  logic [NUM_CH*WS_W-1:0] ch_wait_cfg,
  output logic                   as_n_s,
  output logic                   uds_n_s,
  output logic                   lds_n_s,
  output logic                   rw_s,
  output logic [1:0]             z2_state,
  output logic [NUM_CH-1:0]      cycle_grant,
  output logic                   dtack,
  output logic                   bus_dtack,
  output logic                   ovr_req,
  output logic                   timeout
);

  // state    | meaning
  // ST_IDLE  | no cycle; waiting for AS low with a decode hit
  // ST_START | grant latched; waiting for a data strobe
  // ST_DATA  | burning wait states, then waiting for the target's ready
  // ST_END   | DTACK asserted; waiting for AS to negate
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_END   = 2'd3
  } z2_state_t;

  logic [SYNC_STAGES-1:0][3:0] sync_q;

  always_ff @(posedge MEMCLK) begin
    if (RESET) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], AS_n, UDS_n, LDS_n, RW};
  end

  assign {as_n_s, uds_n_s, lds_n_s, rw_s} = sync_q[SYNC_STAGES-1];

  z2_state_t         state_q, state_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic              dtack_q, dtack_d;
  logic [WS_W-1:0]   wcnt_q, wcnt_d;
  logic [NUM_CH-1:0] hit_sel;
  logic [WS_W-1:0]   hit_cfg;
  logic              granted_ready;
  logic              to_hit;

  // two's-complement trick isolates the lowest set bit = highest priority hit
  always_comb begin
    hit_sel = ch_access & (~ch_access + NUM_CH'(1));
    hit_cfg = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (hit_sel[i]) hit_cfg = hit_cfg | ch_wait_cfg[i*WS_W +: WS_W];
    end
  end

  assign granted_ready = |(ch_ready & grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    dtack_d = dtack_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        dtack_d = 1'b0;
        if (!as_n_s && (|ch_access)) begin
          grant_d = hit_sel;
          wcnt_d  = hit_cfg;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (as_n_s) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end else if (to_hit) begin
          dtack_d = 1'b1;
          state_d = ST_END;
        end else if (!uds_n_s || !lds_n_s) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (as_n_s) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end else if (to_hit) begin
          dtack_d = 1'b1;
          state_d = ST_END;
        end else if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - WS_W'(1);
        end else if (granted_ready) begin
          dtack_d = 1'b1;
          state_d = ST_END;
        end
      end
      ST_END: begin
        if (as_n_s) begin
          dtack_d = 1'b0;
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge MEMCLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      dtack_q <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      dtack_q <= dtack_d;
      wcnt_q  <= wcnt_d;
    end
  end

`ifdef Z2_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TO_W-1:0] tcnt_q;
  logic            timeout_q;
  logic            busy;

  assign busy   = (state_q == ST_START) || (state_q == ST_DATA);
  // fires on the edge where the START+DATA time reaches TIMEOUT_CYCLES
  assign to_hit = busy && (tcnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge MEMCLK) begin
    if (RESET) begin
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE) tcnt_q <= '0;
      else if (busy)          tcnt_q <= tcnt_q + TO_W'(1);
      timeout_q <= to_hit && !as_n_s;
    end
  end

  assign timeout = timeout_q;
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  assign z2_state    = state_q;
  assign cycle_grant = grant_q;
  assign dtack       = dtack_q;
  assign bus_dtack   = dtack_q && (|(grant_q & BUS_MASK));
  assign ovr_req     = (|(grant_q & BUS_MASK)) && !as_n_s;

endmodule

// File: tb/tb_z2_cycle_ctrl.sv
// Scoreboard bench for z2_cycle_ctrl: driver pushes expected cycle outcomes, a negedge
// monitor reconstructs each bus cycle from the outputs and compares.
module tb_z2_cycle_ctrl;
  localparam int NUM_CH = 5;
  localparam int WS_W   = 3;
  localparam int TO_CYC = 16;
  localparam logic [NUM_CH-1:0] MASK = 5'b00111;

  logic MEMCLK = 1'b0;
  logic RESET = 1'b1;
  logic AS_n = 1'b1, UDS_n = 1'b1, LDS_n = 1'b1, RW = 1'b1;
  logic [NUM_CH-1:0] ch_access = '0;
  logic [NUM_CH-1:0] ch_ready = '0;
  logic [NUM_CH*WS_W-1:0] ch_wait_cfg = '0;
  logic as_n_s, uds_n_s, lds_n_s, rw_s;
  logic [1:0] z2_state;
  logic [NUM_CH-1:0] cycle_grant;
  logic dtack, bus_dtack, ovr_req, timeout;

  z2_cycle_ctrl #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(2), .WS_W(WS_W), .BUS_MASK(MASK), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .MEMCLK(MEMCLK), .RESET(RESET), .AS_n(AS_n), .UDS_n(UDS_n), .LDS_n(LDS_n), .RW(RW),
    .ch_access(ch_access), .ch_ready(ch_ready), .ch_wait_cfg(ch_wait_cfg),
    .as_n_s(as_n_s), .uds_n_s(uds_n_s), .lds_n_s(lds_n_s), .rw_s(rw_s),
    .z2_state(z2_state), .cycle_grant(cycle_grant), .dtack(dtack),
    .bus_dtack(bus_dtack), .ovr_req(ovr_req), .timeout(timeout)
  );

  always #5 MEMCLK = ~MEMCLK;

  typedef struct {
    logic [NUM_CH-1:0] grant;
    bit acked;
    bit bus;
    bit ovr;
    int lat;     // DATA cycles before dtack, -1 = not checked
    int busy;    // START+DATA cycles before dtack, -1 = not checked
    int tpulse;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  function automatic void fail_now(string name);
    total++;
    bad++;
    $display("FAIL %s bound expired", name);
  endfunction

  function automatic int low_idx(logic [NUM_CH-1:0] a);
    for (int i = 0; i < NUM_CH; i++) if (a[i]) return i;
    return -1;
  endfunction

  // monitor
  bit in_cyc = 0, m_acked = 0, m_bus = 0, m_ovr = 0;
  int m_dcnt = 0, m_bcnt = 0, m_tp = 0;
  logic [NUM_CH-1:0] m_g0, m_ge;

  always @(negedge MEMCLK) begin
    exp_t e;
    if (z2_state != 2'd0 && !in_cyc) begin
      in_cyc = 1; m_g0 = cycle_grant; m_dcnt = 0; m_bcnt = 0; m_tp = 0; m_acked = 0;
    end
    if (in_cyc) begin
      if (z2_state == 2'd2) m_dcnt++;
      if (z2_state == 2'd1 || z2_state == 2'd2) m_bcnt++;
      if (timeout) m_tp++;
      if (dtack && !m_acked) begin
        m_acked = 1; m_bus = bus_dtack; m_ovr = ovr_req; m_ge = cycle_grant;
      end
      if (z2_state == 2'd0) begin
        in_cyc = 0;
        if (sb.size() == 0) begin
          fail_now("unexpected_cycle");
        end else begin
          e = sb.pop_front();
          chk("grant_start", int'(m_g0), int'(e.grant));
          chk("acked", int'(m_acked), int'(e.acked));
          if (e.acked && m_acked) begin
            chk("bus_dtack", int'(m_bus), int'(e.bus));
            chk("ovr_req", int'(m_ovr), int'(e.ovr));
            chk("grant_at_ack", int'(m_ge), int'(e.grant));
          end
          if (e.lat >= 0) chk("data_latency", m_dcnt, e.lat);
          if (e.busy >= 0) chk("busy_latency", m_bcnt, e.busy);
          chk("timeout_pulses", m_tp, e.tpulse);
          chk("idle_grant", int'(cycle_grant), 0);
          chk("idle_dtack", int'(dtack), 0);
          chk("idle_ovr", int'(ovr_req), 0);
        end
      end
    end
  end

  task automatic recover();
    RESET = 1; AS_n = 1; UDS_n = 1; LDS_n = 1; ch_ready = '0;
    repeat (2) @(negedge MEMCLK);
    RESET = 0;
    @(negedge MEMCLK);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (z2_state != 2'd0 && guard < 20) begin @(negedge MEMCLK); guard++; end
    if (z2_state != 2'd0) begin fail_now("idle_wait"); recover(); end
  endtask

  task automatic run_txn(input logic [NUM_CH-1:0] acc, input logic [NUM_CH*WS_W-1:0] cfg,
                         input int k, input bit abort, input bit scramble,
                         input logic [NUM_CH-1:0] scr_val, input bit rst_end);
    int idx, n, cnt, guard;
    exp_t e;
    logic [NUM_CH-1:0] gbit;
    idx = low_idx(acc);
    gbit = 5'b00001 << idx;
    n = int'(cfg[idx*WS_W +: WS_W]);
    e.grant = gbit; e.acked = !abort; e.bus = !abort && MASK[idx]; e.ovr = MASK[idx];
    e.lat = abort ? -1 : ((n + 1 > k) ? n + 1 : k);
    e.busy = -1; e.tpulse = 0;
    sb.push_back(e);
    ch_access = acc; ch_wait_cfg = cfg; RW = 1'($urandom);
    ch_ready = 5'($urandom) & ~gbit;
    if (k == 0 && !abort) ch_ready = ch_ready | gbit;
    @(negedge MEMCLK);
    AS_n = 0;
    guard = 0;
    while (z2_state == 2'd0 && guard < 20) begin @(negedge MEMCLK); guard++; end
    if (z2_state == 2'd0) begin
      fail_now("start_wait"); void'(sb.pop_back()); recover(); return;
    end
    if (scramble) ch_access = scr_val;
    repeat ($urandom_range(0, 2)) @(negedge MEMCLK);
    case ($urandom_range(0, 2))
      0: UDS_n = 0;
      1: LDS_n = 0;
      default: begin UDS_n = 0; LDS_n = 0; end
    endcase
    guard = 0;
    while (z2_state != 2'd2 && guard < 20) begin @(negedge MEMCLK); guard++; end
    if (z2_state != 2'd2) begin fail_now("data_wait"); recover(); return; end
    if (abort) begin
      repeat ($urandom_range(0, 3)) @(negedge MEMCLK);
      AS_n = 1; UDS_n = 1; LDS_n = 1;
    end else begin
      cnt = 1;
      if (cnt == k) ch_ready = ch_ready | gbit;
      guard = 0;
      while (!dtack && guard < 60) begin
        @(negedge MEMCLK); guard++;
        if (z2_state == 2'd2) begin
          cnt++;
          if (cnt == k) ch_ready = ch_ready | gbit;
        end
      end
      if (!dtack) begin fail_now("dtack_wait"); recover(); return; end
      if (rst_end) begin
        RESET = 1; AS_n = 1; UDS_n = 1; LDS_n = 1;
        @(negedge MEMCLK);
        RESET = 0;
      end else begin
        repeat ($urandom_range(0, 2)) @(negedge MEMCLK);
        AS_n = 1; UDS_n = 1; LDS_n = 1;
      end
    end
    wait_idle();
    ch_ready = '0;
    @(negedge MEMCLK);
  endtask

  task automatic hung_cycle();
    exp_t e;
    int guard;
    e.grant = 5'b00010; e.ovr = MASK[1]; e.lat = -1;
`ifdef Z2_TIMEOUT_EN
    e.acked = 1; e.bus = MASK[1]; e.busy = TO_CYC; e.tpulse = 1;
`else
    e.acked = 0; e.bus = 0; e.busy = -1; e.tpulse = 0;
`endif
    sb.push_back(e);
    ch_access = 5'b00010; ch_wait_cfg = '0; ch_ready = 5'b11101;
    @(negedge MEMCLK);
    AS_n = 0; UDS_n = 0; LDS_n = 0;
`ifdef Z2_TIMEOUT_EN
    guard = 0;
    while (!dtack && guard < 60) begin @(negedge MEMCLK); guard++; end
    if (!dtack) fail_now("timeout_dtack_wait");
    @(negedge MEMCLK);
`else
    guard = 0;
    while (guard < 1000) begin @(negedge MEMCLK); guard++; end
`endif
    AS_n = 1; UDS_n = 1; LDS_n = 1;
    wait_idle();
    ch_ready = '0;
    @(negedge MEMCLK);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge MEMCLK);
    chk("rst_state", int'(z2_state), 0);
    chk("rst_grant", int'(cycle_grant), 0);
    chk("rst_dtack", int'(dtack), 0);
    chk("rst_sync", int'({as_n_s, uds_n_s, lds_n_s, rw_s}), 15);
    chk("rst_bus_ovr", int'({bus_dtack, ovr_req}), 0);
    chk("rst_timeout", int'(timeout), 0);
    RESET = 0;
    @(negedge MEMCLK);

    run_txn(5'b00010, 15'h0000, 0, 0, 0, '0, 0);
    run_txn(5'b00100, 15'(3) << 6, 0, 0, 0, '0, 0);
    run_txn(5'b10100, 15'(2) << 6, 0, 0, 1, 5'b10000, 0);
    run_txn(5'b10000, 15'(1) << 12, 0, 0, 0, '0, 0);
    run_txn(5'b00001, 15'h0000, 1, 1, 0, '0, 0);
    run_txn(5'b01000, 15'(1) << 9, 4, 0, 0, '0, 0);
    run_txn(5'b00010, 15'h0000, 0, 0, 0, '0, 1);
    hung_cycle();

    for (int t = 0; t < 60; t++) begin
      run_txn(5'($urandom_range(1, 31)), 15'($urandom), $urandom_range(0, 5),
              ($urandom_range(0, 5) == 0), 1'($urandom), 5'($urandom), 0);
    end

    repeat (3) @(negedge MEMCLK);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
